// File: rtl/power_emulator_mmio_if.sv
// Word-addressed MMIO slave bus for power_emulator_mmio.
// Read data is registered inside the slave and holds between reads.
interface power_emulator_mmio_if #(
  parameter int ADDR_W = 4
) ();
  logic              s_read;
  logic              s_write;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [31:0]       s_rdata;

  modport master (
    output s_read, s_write, s_addr, s_wdata,
    input  s_rdata
  );

  modport slave (
    input  s_read, s_write, s_addr, s_wdata,
    output s_rdata
  );
endinterface

// File: rtl/power_emulator_mmio.sv
// Multi-channel MMIO front-end: one start/finish sequencer per core, sticky W1C status, level irq.
// Define POWER_EMU_TIMEOUT_EN to build the per-channel WAIT timeout (limit in CFG[31:16]).
//   state    | meaning
//   ST_IDLE  | channel free, accepts a CTRL start
//   ST_START | core_start asserted for this one cycle
//   ST_WAIT  | waiting for core_fin (or the timeout limit)
module power_emulator_mmio #(
  parameter int CH     = 2,
  parameter int RES_W  = 36,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  power_emulator_mmio_if.slave bus,
  output logic                 irq,
  output logic [CH-1:0]        core_start,
  input  logic [CH-1:0]        core_fin,
  input  logic [CH*RES_W-1:0]  core_result
);
  localparam int WPR    = (RES_W + 31) / 32;
  localparam int NWORDS = CH * WPR;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;

  state_t [CH-1:0]            r_state;
  logic   [CH-1:0][RES_W-1:0] r_result;
  logic   [CH-1:0]            r_done;
  logic   [CH-1:0]            r_err_busy;
  logic   [CH-1:0]            r_irq_en;
  logic   [CH-1:0]            r_core_start;
  logic                       r_irq;
  logic   [31:0]              r_rdata;

  logic [ADDR_W-1:0]         w_addr;
  logic                      w_wr_ctrl, w_wr_status, w_wr_err, w_wr_cfg;
  logic [CH-1:0]             w_busy, w_req, w_clr_done, w_clr_err_busy, w_err_tmo;
  logic [31:0]               w_status, w_err, w_cfg, w_rdata;
  logic [CH-1:0][WPR*32-1:0] w_pad;
  logic [NWORDS-1:0][31:0]   w_words;
  logic                      w_unused;

  assign w_addr      = bus.s_addr;
  assign w_wr_ctrl   = bus.s_write && (w_addr == ADDR_W'(0));
  assign w_wr_status = bus.s_write && (w_addr == ADDR_W'(1));
  assign w_wr_err    = bus.s_write && (w_addr == ADDR_W'(2));
  assign w_wr_cfg    = bus.s_write && (w_addr == ADDR_W'(3));

  assign w_req          = w_wr_ctrl   ? bus.s_wdata[CH-1:0]   : '0;
  assign w_clr_done     = w_wr_status ? bus.s_wdata[16 +: CH] : '0;
  assign w_clr_err_busy = w_wr_err    ? bus.s_wdata[CH-1:0]   : '0;
  assign w_unused       = ^bus.s_wdata;

`ifdef POWER_EMU_TIMEOUT_EN
  logic [CH-1:0][15:0] r_cnt;
  logic [CH-1:0]       r_err_tmo;
  logic [15:0]         r_limit;
  logic [CH-1:0]       w_clr_err_tmo;

  assign w_clr_err_tmo = w_wr_err ? bus.s_wdata[16 +: CH] : '0;
  assign w_err_tmo     = r_err_tmo;
`else
  assign w_err_tmo = '0;
`endif

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_busy[c] = (r_state[c] != ST_IDLE);
      w_pad[c]  = (WPR*32)'(r_result[c]);
    end
  end

  assign w_words = w_pad;

  always_comb begin
    w_status = '0;
    w_status[CH-1:0]  = w_busy;
    w_status[16 +: CH] = r_done;
    w_err = '0;
    w_err[CH-1:0]  = r_err_busy;
    w_err[16 +: CH] = w_err_tmo;
    w_cfg = '0;
    w_cfg[CH-1:0] = r_irq_en;
`ifdef POWER_EMU_TIMEOUT_EN
    w_cfg[31:16] = r_limit;
`endif
  end

  // CTRL and unmapped addresses fall through to zero.
  always_comb begin
    w_rdata = '0;
    if (w_addr == ADDR_W'(1)) w_rdata = w_status;
    if (w_addr == ADDR_W'(2)) w_rdata = w_err;
    if (w_addr == ADDR_W'(3)) w_rdata = w_cfg;
    for (int w = 0; w < NWORDS; w++) begin
      if (w_addr == ADDR_W'(4 + w)) w_rdata = w_words[w];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (bus.s_read) begin
      r_rdata <= w_rdata;
    end
  end

  // Sticky bits clear first; same-cycle sets below override the W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) r_state[c] <= ST_IDLE;
      r_result     <= '0;
      r_done       <= '0;
      r_err_busy   <= '0;
      r_irq_en     <= '0;
      r_core_start <= '0;
      r_irq        <= 1'b0;
`ifdef POWER_EMU_TIMEOUT_EN
      r_cnt     <= '0;
      r_err_tmo <= '0;
      r_limit   <= '0;
`endif
    end else begin
      r_core_start <= '0;
      r_done       <= r_done & ~w_clr_done;
      r_err_busy   <= (r_err_busy & ~w_clr_err_busy) | (w_req & w_busy);
      r_irq        <= |(r_done & r_irq_en);
      if (w_wr_cfg) r_irq_en <= bus.s_wdata[CH-1:0];
`ifdef POWER_EMU_TIMEOUT_EN
      r_err_tmo <= r_err_tmo & ~w_clr_err_tmo;
      if (w_wr_cfg) r_limit <= bus.s_wdata[31:16];
`endif
      for (int c = 0; c < CH; c++) begin
        case (r_state[c])
          ST_IDLE: begin
            if (w_req[c]) begin
              r_state[c]      <= ST_START;
              r_core_start[c] <= 1'b1;
            end
          end
          ST_START: begin
            r_state[c] <= ST_WAIT;
`ifdef POWER_EMU_TIMEOUT_EN
            r_cnt[c] <= '0;
`endif
          end
          ST_WAIT: begin
            if (core_fin[c]) begin
              r_state[c]  <= ST_IDLE;
              r_result[c] <= core_result[c*RES_W +: RES_W];
              r_done[c]   <= 1'b1;
            end
`ifdef POWER_EMU_TIMEOUT_EN
            else if ((r_limit != 16'd0) && (r_cnt[c] + 16'd1 == r_limit)) begin
              r_state[c]   <= ST_IDLE;
              r_err_tmo[c] <= 1'b1;
            end else begin
              r_cnt[c] <= r_cnt[c] + 16'd1;
            end
`endif
          end
          default: r_state[c] <= ST_IDLE;
        endcase
      end
    end
  end

  assign core_start  = r_core_start;
  assign irq         = r_irq;
  assign bus.s_rdata = r_rdata;
endmodule

// File: doc/power_emulator_mmio.md
# power_emulator_mmio

Multi-channel, parametrised memory-mapped front-end for the power-emulator compute cores. Replaces the single-core, hard-wired register file with one sequencer per channel: a start/finish handshake, result capture into 32-bit readable words, sticky done/error status with write-1-to-clear, and a level interrupt. It sits between the bus slave port and `CH` external core instances, which expose `start`, `fin` and `result` signals.

## Interface
- `CH`, 2: number of core channels, 1..16.
- `RES_W`, 36: core result width in bits, 1..128. `WPR = ceil(RES_W/32)` is the number of result words per channel.
- `ADDR_W`, 4: slave address width. The address map must satisfy 4 + CH*WPR <= 2^ADDR_W.
- `clk` in 1: sole clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `s_read` in 1: read strobe, sampled at the rising edge.
- `s_write` in 1: write strobe, sampled at the rising edge.
- `s_addr` in ADDR_W: word address.
- `s_wdata` in 32: write data.
- `s_rdata` out 32: registered read data.
- `irq` out 1: level interrupt.
- `core_start` out CH: one-cycle start pulse per channel.
- `core_fin` in CH: core completion, sampled while the channel waits.
- `core_result` in CH*RES_W: channel c occupies bits [c*RES_W +: RES_W].

## Operation
- Address map:
  - 0 CTRL (write-only): writing bit c = 1 requests a start on channel c. Bits >= CH are ignored. Reads return 0.
  - 1 STATUS: bits [CH-1:0] = busy, bits [16+CH-1:16] = done (sticky). Writing 1 to a done bit clears it.
  - 2 ERR (W1C): bits [CH-1:0] = start-while-busy error, bits [16+CH-1:16] = timeout error.
  - 3 CFG (R/W): bits [CH-1:0] = irq_en. Bits [31:16] = timeout limit, meaningful only with the macro defined.
  - 4 + c*WPR + k (read-only): result word k of channel c = captured result bits [32k+31:32k], zero-padded above RES_W.
  - Unmapped addresses: reads return 0, writes are ignored.
- Per-channel FSM, states IDLE, START, WAIT:
  - IDLE -> START on a CTRL write with bit c set.
  - START drives `core_start[c]` = 1 for exactly one cycle, then moves to WAIT.
  - WAIT -> IDLE when `core_fin[c]` = 1. On that edge, `core_result` is captured into the channel's result registers and `done[c]` is set.
  - busy[c] = 1 in START and WAIT.
- A start request while busy[c] = 1 is ignored, and ERR bit c is set.
- `irq` = OR over c of (done[c] & irq_en[c]), registered. It asserts one cycle after done or irq_en is set.
- Result registers keep the last captured value until the next completion. A new start does not clear them.
- Simultaneous events:
  - A done set and a W1C of the same bit in the same cycle: set wins.
  - A start write and `core_fin` for the same channel in the same cycle: the channel is busy, so the start is ignored and the error is flagged.
  - Independent channels can start in the same CTRL write.
- A `core_fin` outside WAIT is ignored.
- Reset, including mid-operation:
  - All FSMs go to IDLE.
  - `core_start`, `s_rdata`, `irq`, STATUS, ERR, CFG and the result registers all go to 0.

## Timing
- Write at edge N with CTRL bit c set and channel idle: `core_start[c]` = 1 during cycle N+1, busy reads 1 from N+1.
- Earliest `core_fin` accepted is at edge N+2.
- `core_fin` at edge M: result and done are visible to a read issued at edge M+1. `irq` is high after edge M+1.
- Read issued at edge R: `s_rdata` is valid after edge R and holds until the next read.
- A read and a write to the same register at the same edge return the pre-write value.

## Configuration
- `POWER_EMU_TIMEOUT_EN` defined:
  - A 16-bit counter per channel clears on entering WAIT and increments each cycle in WAIT.
  - When the counter equals a nonzero CFG[31:16], the channel returns to IDLE without capturing a result and sets timeout ERR bit c. done stays 0.
  - A limit of 0 disables the timeout.
- Not defined: no counters are built, CFG[31:16] reads 0 and ignores writes, and timeout ERR bits are constant 0.

## Test plan
- Reset with CH=2, RES_W=36, then read every address 0..7 -> every read returns 0, `irq` = 0, `core_start` = 0.
- Write CTRL = 1 -> `core_start` = 01 for one cycle; STATUS reads 0x1. Drive `core_fin[0]` with result 36'hA_1234_5678 -> address 4 reads 0x12345678, address 5 reads 0xA, STATUS reads 0x10000.
- CFG = 0x1, complete channel 0 -> `irq` = 1. Write STATUS = 0x10000 -> done clears, `irq` = 0 the following cycle.
- Start channel 1, then write CTRL = 2 again while busy -> ERR reads 0x2 and only one `core_start[1]` pulse appears. Write ERR = 0x2 -> ERR reads 0.
- With `POWER_EMU_TIMEOUT_EN` and CFG = 0x0005_0000, start channel 0 and never assert fin -> busy drops after 5 WAIT cycles, ERR reads 0x10000, result registers are unchanged.
- Assert `reset` while channel 1 is in WAIT -> all state returns to 0. A `core_fin[1]` after release is ignored.
